bless_ni: RTL

Node-side network interface for the bufferless age-arbitrated deflection router. It is the other end of the router's local port 4.
- Transmit: accepts flits from the core, stamps the control word, and injects them only when the router grants `port4_ready`.
- Receive: takes ejected control/data pairs from the router, aligns them, buffers them, and hands them to the core over a valid/ready handshake.
- Ejection never stalls. When the receive FIFO is full, the flit is dropped and counted.

---
 rtl/bless_ni_pkg.sv | 39 +++
 rtl/ni_fifo.sv | 44 ++++
 rtl/bless_ni.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bless_ni_pkg.sv
// rtl/bless_ni_pkg.sv - shared control-word fields, widths and FIFO entry types for bless_ni
package bless_ni_pkg;

    localparam int addr_w    = 4;
    localparam int age_w     = 4;
    localparam int data_w    = 16;
    localparam int control_w = 16;

    // Control word layout: {unused[15:13], age[12:9], src[8:5], dest[4:1], valid[0]}
    localparam int valid_f = 0;
    localparam int dest_f  = 1;
    localparam int src_f   = dest_f + addr_w;
    localparam int age_f   = src_f + addr_w;

    typedef struct packed {
        logic [addr_w-1:0] dest;
        logic [data_w-1:0] data;
    } tx_entry_t;

    typedef struct packed {
        logic [addr_w-1:0] src;
        logic [age_w-1:0]  age;
        logic [data_w-1:0] data;
    } rx_entry_t;

    function automatic logic [control_w-1:0] make_ctrl(
        input logic              valid,
        input logic [addr_w-1:0] dest,
        input logic [addr_w-1:0] src
    );
        logic [control_w-1:0] c;
        c                   = '0;
        c[valid_f]          = valid;
        c[dest_f +: addr_w] = dest;
        c[src_f +: addr_w]  = src;
        return c;
    endfunction

endpackage

// File: rtl/ni_fifo.sv
// rtl/ni_fifo.sv - synchronous FIFO with full/empty flags; a same-edge pop frees a slot for a push
module ni_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic [W-1:0] mem [DEPTH];
    logic         do_pop;
    logic         do_push;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/bless_ni.sv
// rtl/bless_ni.sv - node interface for the bufferless deflection router local port; optional stats via BLESS_NI_STATS_EN
module bless_ni
    import bless_ni_pkg::*;
#(
    parameter logic [addr_w-1:0] addr     = 4'b0101,
    parameter int                TX_DEPTH = 4,
    parameter int                RX_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [addr_w-1:0]    tx_dest,
    input  logic [data_w-1:0]    tx_data,
    input  logic                 port4_ready,
    output logic [control_w-1:0] port4_ci,
    output logic [data_w-1:0]    port4_di,
    input  logic [control_w-1:0] port4_co,
    input  logic [data_w-1:0]    port4_do,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [addr_w-1:0]    rx_src,
    output logic [age_w-1:0]     rx_age,
    output logic [data_w-1:0]    rx_data,
    output logic [7:0]           drop_cnt,
    output logic                 misroute,
    output logic [15:0]          inj_cnt,
    output logic [15:0]          ej_cnt,
    output logic [15:0]          stall_cnt
);

    tx_entry_t         tx_in;
    tx_entry_t         tx_head;
    logic              tx_full;
    logic              tx_empty;
    logic              ready_q;
    logic              inject;

    rx_entry_t         rx_in;
    rx_entry_t         rx_head;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_pop;
    logic              rx_drop;

    logic              ej;
    logic              al_valid;
    logic [addr_w-1:0] al_src;
    logic [age_w-1:0]  al_age;
    logic              unused_ctrl;

    // ready_q keeps tx_ready low throughout reset and for the edge it is released on
    assign tx_ready = ready_q && !tx_full;
    assign tx_in    = '{dest: tx_dest, data: tx_data};
    assign inject   = !tx_empty && port4_ready;
    assign port4_ci = tx_empty ? '0 : make_ctrl(inject, tx_head.dest, addr);
    assign port4_di = tx_empty ? '0 : tx_head.data;

    ni_fifo #(.W($bits(tx_entry_t)), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_valid && tx_ready),
        .push_data (tx_in),
        .pop       (inject),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    assign ej          = port4_co[valid_f];
    assign unused_ctrl = ^port4_co[control_w-1:age_f+age_w];

    // Control arrives one cycle ahead of its data; hold src/age until the data shows up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q  <= 1'b0;
            al_valid <= 1'b0;
            al_src   <= '0;
            al_age   <= '0;
            misroute <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ready_q  <= 1'b1;
            al_valid <= ej;
            if (ej) begin
                al_src <= port4_co[src_f +: addr_w];
                al_age <= port4_co[age_f +: age_w];
            end
            if (ej && (port4_co[dest_f +: addr_w] != addr)) misroute <= 1'b1;
            if (rx_drop && (drop_cnt != 8'hFF))             drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign rx_in    = '{src: al_src, age: al_age, data: port4_do};
    assign rx_pop   = !rx_empty && rx_ready;
    assign rx_drop  = al_valid && rx_full && !rx_pop;
    assign rx_valid = !rx_empty;
    assign rx_src   = rx_head.src;
    assign rx_age   = rx_head.age;
    assign rx_data  = rx_head.data;

    ni_fifo #(.W($bits(rx_entry_t)), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (al_valid),
        .push_data (rx_in),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

`ifdef BLESS_NI_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_cnt   <= '0;
            ej_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (inject && (inj_cnt != 16'hFFFF))                          inj_cnt   <= inj_cnt + 16'd1;
            if (ej && (ej_cnt != 16'hFFFF))                               ej_cnt    <= ej_cnt + 16'd1;
            if (!tx_empty && !port4_ready && (stall_cnt != 16'hFFFF))     stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign inj_cnt   = '0;
    assign ej_cnt    = '0;
    assign stall_cnt = '0;
`endif

endmodule
